// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the memory-stage access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CTRL_REGWRITE  = 3;
    localparam int CTRL_RESULTSRC = 1;  // low bit of the 2-bit ResultSrc field
    localparam int CTRL_MEMWRITE  = 0;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // Legal size code and natural alignment; unsigned sizes exist for loads only.
    function automatic logic f3_access_ok(input logic [2:0] f3,
                                          input logic       is_store,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half of a load word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : M-stage data-memory access FSM with registered request
//               channel, load alignment and cycle-bounded timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  CtrlM,
    input  logic [2:0]  Funct3M,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        FaultM
);

    localparam logic [31:0] c_TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    mem_state_t  r_state;
    mem_state_t  w_state_next;

    logic        r_req_valid;
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;
    logic [31:0] r_rdata;
    logic [31:0] r_cnt;

    logic        w_store;
    logic        w_load;
    logic        w_access;
    logic        w_ok;
    logic        w_to_hit;
    logic        w_latch;
    logic        w_capture;
    logic        w_clear_rd;
    logic [3:0]  w_lane_be;
    logic [31:0] w_lane_wdata;
    logic [31:0] w_load_word;
    logic        w_unused_regwrite;

    assign w_store  = CtrlM[CTRL_MEMWRITE];
    assign w_load   = (CtrlM[CTRL_RESULTSRC +: 2] == RESULTSRC_LOAD);
    assign w_access = w_store | w_load;
    assign w_ok     = f3_access_ok(Funct3M, w_store, ALUResultM[1:0]);
    assign w_to_hit = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);
    assign w_unused_regwrite = CtrlM[CTRL_REGWRITE];

    // Store lanes: replicate the datum so any byte enable picks the right lane.
    always_comb begin
        case (Funct3M[1:0])
            2'b00: begin
                w_lane_be    = 4'b0001 << ALUResultM[1:0];
                w_lane_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_lane_be    = 4'b0011 << ALUResultM[1:0];
                w_lane_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                w_lane_be    = 4'b1111;
                w_lane_wdata = WriteDataM;
            end
        endcase
    end

    load_align u_load_align (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_load_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        StallM       = 1'b0;
        FaultM       = 1'b0;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        w_clear_rd   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (w_ok) begin
                        StallM       = 1'b1;
                        w_latch      = 1'b1;
                        w_state_next = S_REQ;
                    end else begin
                        FaultM     = 1'b1;
                        w_clear_rd = 1'b1;
                    end
                end
            end
            S_REQ: begin
                StallM = 1'b1;
                if (r_req_valid && dmem_req_ready) begin
                    w_state_next = r_we ? S_DONE : S_WAIT;
                end else if (w_to_hit) begin
                    FaultM       = 1'b1;
                    w_clear_rd   = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_WAIT: begin
                StallM = 1'b1;
                if (dmem_rsp_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_DONE;
                end else if (w_to_hit) begin
                    FaultM       = 1'b1;
                    w_clear_rd   = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_addr_lo   <= '0;
            r_funct3    <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_latch) begin
                r_req_valid <= 1'b1;
                r_addr      <= {ALUResultM[31:2], 2'b00};
                r_we        <= w_store;
                r_be        <= w_store ? w_lane_be : 4'b0000;
                r_wdata     <= w_store ? w_lane_wdata : 32'd0;
                r_addr_lo   <= ALUResultM[1:0];
                r_funct3    <= Funct3M;
            end else if ((r_state == S_REQ) && (w_state_next != S_REQ)) begin
                r_req_valid <= 1'b0;
            end

            if (w_capture) begin
                r_rdata <= w_load_word;
            end else if (w_clear_rd) begin
                r_rdata <= '0;
            end

            if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + 32'd1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign dmem_req_valid = r_req_valid;
    assign dmem_addr      = r_addr;
    assign dmem_we        = r_we;
    assign dmem_be        = r_be;
    assign dmem_wdata     = r_wdata;
    assign ReadDataM      = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int unsigned TIMEOUT = 4;
    localparam logic [3:0] c_CTRL_ST   = 4'b0001;
    localparam logic [3:0] c_CTRL_LD   = 4'b1010;
    localparam logic [3:0] c_CTRL_NONE = 4'b0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [3:0]  CtrlM;
    logic [2:0]  Funct3M;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        FaultM;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .ALUResultM     (ALUResultM),
        .WriteDataM     (WriteDataM),
        .CtrlM          (CtrlM),
        .Funct3M        (Funct3M),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .ReadDataM      (ReadDataM),
        .StallM         (StallM),
        .FaultM         (FaultM)
    );

    task automatic drive(input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ctrl, input logic [2:0] f3);
        ALUResultM = addr;
        WriteDataM = wd;
        CtrlM      = ctrl;
        Funct3M    = f3;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(32'h0, 32'h0, c_CTRL_NONE, F3_B);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({dmem_req_valid, dmem_we, dmem_be, StallM, FaultM} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctl: got valid=%b we=%b be=%b stall=%b fault=%b, want all 0",
                     dmem_req_valid, dmem_we, dmem_be, StallM, FaultM);
        end
        n_vec++;
        if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_payload: got addr=%h wdata=%h, want 0/0", dmem_addr, dmem_wdata);
        end
        n_vec++;
        if (ReadDataM !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h want 00000000", ReadDataM);
        end
    endtask

    task automatic test_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd, input int ready_delay);
        req_t got;
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        @(negedge clk);
        drive(addr, wd, c_CTRL_ST, f3);
        dmem_req_ready = 1'b0;
        req_q.push_back(req_t'{addr: waddr, we: 1'b1, be: exp_be, wdata: exp_wd});
        #1;
        n_vec++;
        if (StallM !== 1'b1 || dmem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL st_idle: got stall=%b valid=%b want 1/0", StallM, dmem_req_valid);
        end
        for (int i = 0; i <= ready_delay; i++) begin
            @(negedge clk);
            if (i == ready_delay) dmem_req_ready = 1'b1;
            #1;
            n_vec++;
            if (dmem_req_valid !== 1'b1 || StallM !== 1'b1 || dmem_addr !== waddr) begin
                n_err++;
                $display("FAIL st_req_hold: got valid=%b stall=%b addr=%h want 1/1/%h",
                         dmem_req_valid, StallM, dmem_addr, waddr);
            end
        end
        n_vec++;
        if (req_q.size() == 0) begin
            n_err++;
            $display("FAIL st_scoreboard: got empty queue want one entry");
        end else begin
            got = req_q.pop_front();
            if (dmem_addr !== got.addr || dmem_we !== got.we || dmem_be !== got.be || dmem_wdata !== got.wdata) begin
                n_err++;
                $display("FAIL st_payload: got addr=%h we=%b be=%b wdata=%h want addr=%h we=%b be=%b wdata=%h",
                         dmem_addr, dmem_we, dmem_be, dmem_wdata, got.addr, got.we, got.be, got.wdata);
            end
        end
        @(negedge clk);
        dmem_req_ready = 1'b0;
        drive(32'h0, 32'h0, c_CTRL_NONE, F3_B);
        #1;
        n_vec++;
        if (StallM !== 1'b0 || dmem_req_valid !== 1'b0 || FaultM !== 1'b0) begin
            n_err++;
            $display("FAIL st_done: got stall=%b valid=%b fault=%b want 0/0/0", StallM, dmem_req_valid, FaultM);
        end
    endtask

    task automatic test_load(input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] rdata, input logic [31:0] exp, input int rsp_delay);
        req_t got;
        logic [31:0] want;
        @(negedge clk);
        drive(addr, 32'h0, c_CTRL_LD, f3);
        dmem_req_ready = 1'b1;
        req_q.push_back(req_t'{addr: {addr[31:2], 2'b00}, we: 1'b0, be: 4'b0000, wdata: 32'h0});
        rd_q.push_back(exp);
        #1;
        n_vec++;
        if (StallM !== 1'b1) begin
            n_err++;
            $display("FAIL ld_idle_stall: got %b want 1", StallM);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (req_q.size() == 0 || dmem_req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ld_handshake: got valid=%b queue=%0d want 1/1", dmem_req_valid, req_q.size());
        end else begin
            got = req_q.pop_front();
            if (dmem_addr !== got.addr || dmem_we !== got.we || dmem_be !== got.be) begin
                n_err++;
                $display("FAIL ld_payload: got addr=%h we=%b be=%b want addr=%h we=%b be=%b",
                         dmem_addr, dmem_we, dmem_be, got.addr, got.we, got.be);
            end
        end
        for (int i = 1; i <= rsp_delay; i++) begin
            @(negedge clk);
            dmem_req_ready = 1'b0;
            if (i == rsp_delay) begin
                dmem_rsp_valid = 1'b1;
                dmem_rdata     = rdata;
            end else begin
                dmem_rdata     = 32'h5A5A5A5A;
            end
            #1;
            n_vec++;
            if (StallM !== 1'b1 || dmem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL ld_wait: got stall=%b valid=%b want 1/0", StallM, dmem_req_valid);
            end
        end
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        drive(32'h0, 32'h0, c_CTRL_NONE, F3_B);
        #1;
        n_vec++;
        want = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hxxxxxxxx;
        if (ReadDataM !== want || StallM !== 1'b0) begin
            n_err++;
            $display("FAIL ld_data: got rdata=%h stall=%b want %h/0", ReadDataM, StallM, want);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (ReadDataM !== want) begin
            n_err++;
            $display("FAIL ld_stable: got %h want %h", ReadDataM, want);
        end
    endtask

    task automatic test_fault;
        logic [31:0] f_addr [6] = '{32'h101, 32'h100, 32'h102, 32'h100, 32'h103, 32'h100};
        logic [3:0]  f_ctrl [6] = '{c_CTRL_LD, c_CTRL_LD, c_CTRL_LD, c_CTRL_ST, c_CTRL_LD, 4'b1011};
        logic [2:0]  f_f3   [6] = '{F3_H, 3'b011, F3_W, F3_BU, F3_HU, 3'b110};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(f_addr[i], 32'hFFFF_FFFF, f_ctrl[i], f_f3[i]);
            #1;
            n_vec++;
            if (FaultM !== 1'b1 || StallM !== 1'b0 || dmem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL fault_%0d: got fault=%b stall=%b valid=%b want 1/0/0",
                         i, FaultM, StallM, dmem_req_valid);
            end
            @(negedge clk);
            drive(32'h0, 32'h0, c_CTRL_NONE, F3_B);
            #1;
            n_vec++;
            if (FaultM !== 1'b0 || dmem_req_valid !== 1'b0 || ReadDataM !== 32'h0) begin
                n_err++;
                $display("FAIL fault_after_%0d: got fault=%b valid=%b rdata=%h want 0/0/00000000",
                         i, FaultM, dmem_req_valid, ReadDataM);
            end
        end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        drive(32'h200, 32'h0, c_CTRL_LD, F3_W);
        dmem_req_ready = 1'b0;
        #1;
        n_vec++;
        if (StallM !== 1'b1) begin
            n_err++;
            $display("FAIL to_idle_stall: got %b want 1", StallM);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (dmem_req_valid !== 1'b1 || StallM !== 1'b1 || FaultM !== (i == 4)) begin
                n_err++;
                $display("FAIL to_req_%0d: got valid=%b stall=%b fault=%b want 1/1/%0d",
                         i, dmem_req_valid, StallM, FaultM, (i == 4));
            end
        end
        @(negedge clk);
        drive(32'h0, 32'h0, c_CTRL_NONE, F3_B);
        #1;
        n_vec++;
        if (dmem_req_valid !== 1'b0 || StallM !== 1'b0 || FaultM !== 1'b0 || ReadDataM !== 32'h0) begin
            n_err++;
            $display("FAIL to_done: got valid=%b stall=%b fault=%b rdata=%h want 0/0/0/00000000",
                     dmem_req_valid, StallM, FaultM, ReadDataM);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        drive(32'h300, 32'h0, c_CTRL_LD, F3_W);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        drive(32'h0, 32'h0, c_CTRL_NONE, F3_B);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({dmem_req_valid, dmem_we, dmem_be, StallM, FaultM} !== 8'h00 ||
            dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || ReadDataM !== 32'h0) begin
            n_err++;
            $display("FAIL midrst: got valid=%b we=%b be=%b stall=%b fault=%b addr=%h wdata=%h rdata=%h want all 0",
                     dmem_req_valid, dmem_we, dmem_be, StallM, FaultM, dmem_addr, dmem_wdata, ReadDataM);
        end
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h11111111;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        #1;
        n_vec++;
        if (ReadDataM !== 32'h0 || StallM !== 1'b0 || dmem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_late_rsp: got rdata=%h stall=%b valid=%b want 00000000/0/0",
                     ReadDataM, StallM, dmem_req_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store(32'h100, 32'hDEADBEEF, F3_W, 4'b1111, 32'hDEADBEEF, 1);
        test_store(32'h103, 32'h000000A5, F3_B, 4'b1000, 32'hA5A5A5A5, 0);
        test_store(32'h102, 32'h1234BEEF, F3_H, 4'b1100, 32'hBEEFBEEF, 0);
        test_load(32'h102, F3_B,  32'h12F45678, 32'hFFFFFFF4, 2);
        test_load(32'h102, F3_BU, 32'h12F45678, 32'h000000F4, 2);
        test_load(32'h100, F3_H,  32'h12F48678, 32'hFFFF8678, 1);
        test_load(32'h102, F3_HU, 32'h92F45678, 32'h000092F4, 1);
        test_load(32'h104, F3_W,  32'h89ABCDEF, 32'h89ABCDEF, 1);
        test_fault();
        test_load(32'h101, F3_B,  32'h00007F00, 32'h0000007F, 3);
        test_timeout();
        test_load(32'h103, F3_BU, 32'h80000000, 32'h00000080, 1);
        test_reset_mid();
        test_load(32'h304, F3_W,  32'hCAFEF00D, 32'hCAFEF00D, 2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
